// File: rtl/timer_pkg.sv
// Shared constants and types for the multi-channel timer peripheral.
package timer_pkg;

    // Address spacing between consecutive channel register blocks
    localparam int unsigned CH_STRIDE = 16;

    // Register offsets inside one channel block
    localparam logic [3:0] OFF_CTRL  = 4'h0;
    localparam logic [3:0] OFF_DIV   = 4'h4;
    localparam logic [3:0] OFF_COUNT = 4'h8;
    localparam logic [3:0] OFF_CMP   = 4'hC;

    // CTRL bit positions
    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_PERIODIC = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;
    localparam int unsigned CTRL_W        = 3;

    // Software-visible state of one channel, exported for readback
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       div;
        logic [31:0]       count;
        logic [31:0]       cmp;
    } ch_regs_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/DIV/COUNT/CMP registers, prescaler and compare-match logic.
module timer_channel
    import timer_pkg::*;
#(
    parameter logic [31:0] DEFAULT_DIV = 32'd50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ctrl,
    input  logic        wr_div,
    input  logic        wr_count,
    input  logic        wr_cmp,
    input  logic [31:0] wdata,
    output ch_regs_t    regs,
    output logic        match
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [31:0]       div_q;
    logic [31:0]       count_q;
    logic [31:0]       cmp_q;
    logic [31:0]       psc_q;
    logic              run;
    logic              tick;
    logic              at_cmp;

    assign run    = ctrl_q[CTRL_EN] && (div_q != 32'd0);
    assign tick   = run && (psc_q >= div_q - 32'd1);
    assign at_cmp = (count_q == cmp_q);
    // A software COUNT write in the tick cycle swallows the tick, so no match either
    assign match  = tick && at_cmp && !wr_count;

    assign regs.ctrl  = ctrl_q;
    assign regs.div   = div_q;
    assign regs.count = count_q;
    assign regs.cmp   = cmp_q;

    // Prescaler: counts 0..DIV-1 while running, restarts on tick or any DIV write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q <= 32'd0;
        end else if (wr_div || !run || tick) begin
            psc_q <= 32'd0;
        end else begin
            psc_q <= psc_q + 32'd1;
        end
    end

    // CTRL: software write wins; a one-shot match drops EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else if (wr_ctrl) begin
            ctrl_q <= wdata[CTRL_W-1:0];
        end else if (match && !ctrl_q[CTRL_PERIODIC]) begin
            ctrl_q[CTRL_EN] <= 1'b0;
        end
    end

    // DIV and CMP are plain software registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= DEFAULT_DIV;
            cmp_q <= 32'hFFFF_FFFF;
        end else begin
            if (wr_div) begin
                div_q <= wdata;
            end
            if (wr_cmp) begin
                cmp_q <= wdata;
            end
        end
    end

    // COUNT: software write first, else advance or restart on each tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 32'd0;
        end else if (wr_count) begin
            count_q <= wdata;
        end else if (tick) begin
            if (!at_cmp) begin
                count_q <= count_q + 32'd1;
            end else if (ctrl_q[CTRL_PERIODIC]) begin
                count_q <= 32'd0;
            end
        end
    end

endmodule

// File: rtl/multi_timer_peripheral.sv
// Memory-mapped multi-channel timer: address decode, STATUS flags, read mux and irq.
module multi_timer_peripheral
    import timer_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_F040,
    parameter logic [31:0] DEFAULT_DIV = 32'd50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [31:0] STATUS_OFF = 32'(CH_STRIDE * NUM_CH);

    logic [31:0]       off;
    logic [3:0]        reg_off;
    logic [27:0]       ch_idx;
    logic              ch_hit;
    logic              status_hit;
    ch_regs_t          ch_regs [NUM_CH];
    logic [NUM_CH-1:0] match_vec;
    logic [NUM_CH-1:0] irq_en_vec;
    logic [NUM_CH-1:0] status_q;
    logic [NUM_CH-1:0] status_clr;
    logic              irq_q;

    // Offset arithmetic wraps, so addresses below BASE_ADDR land far out of range
    assign off        = addr - BASE_ADDR;
    assign reg_off    = off[3:0];
    assign ch_idx     = off[31:4];
    assign ch_hit     = (ch_idx < 28'(NUM_CH));
    assign status_hit = (off == STATUS_OFF);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic sel;
        assign sel = we && ch_hit && (ch_idx == 28'(g));

        timer_channel #(
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_ctrl (sel && (reg_off == OFF_CTRL)),
            .wr_div  (sel && (reg_off == OFF_DIV)),
            .wr_count(sel && (reg_off == OFF_COUNT)),
            .wr_cmp  (sel && (reg_off == OFF_CMP)),
            .wdata   (wdata),
            .regs    (ch_regs[g]),
            .match   (match_vec[g])
        );

        assign irq_en_vec[g] = ch_regs[g].ctrl[CTRL_IRQ_EN];
    end

    // Write-1-to-clear mask for STATUS
    always_comb begin
        status_clr = '0;
        if (we && status_hit) begin
            status_clr = wdata[NUM_CH-1:0];
        end
    end

    // STATUS flags: a same-cycle match beats the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~status_clr) | match_vec;
        end
    end

    // irq lags the flags by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(status_q & irq_en_vec);
        end
    end

    assign irq = irq_q;

    // Combinational read mux; unmapped addresses read 0
    always_comb begin
        rdata = '0;
        if (status_hit) begin
            rdata = 32'(status_q);
        end else if (ch_hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_idx == 28'(i)) begin
                    case (reg_off)
                        OFF_CTRL:  rdata = 32'(ch_regs[i].ctrl);
                        OFF_DIV:   rdata = ch_regs[i].div;
                        OFF_COUNT: rdata = ch_regs[i].count;
                        OFF_CMP:   rdata = ch_regs[i].cmp;
                        default:   rdata = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_timer_peripheral.sv
// Self-checking bench for multi_timer_peripheral (2-channel main instance, 4-channel decode check).
module tb_multi_timer_peripheral;

    localparam logic [31:0] BASE    = 32'hFFFF_F040;
    localparam logic [31:0] DEF_DIV = 32'd50000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic [31:0] addr4 = '0;
    logic        we4 = 1'b0;
    logic [31:0] wdata4 = '0;
    logic [31:0] rdata4;
    logic        irq4;

    int n_tests = 0;
    int n_fail  = 0;

    multi_timer_peripheral #(
        .NUM_CH(2), .BASE_ADDR(BASE), .DEFAULT_DIV(DEF_DIV)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    multi_timer_peripheral #(
        .NUM_CH(4), .BASE_ADDR(BASE), .DEFAULT_DIV(DEF_DIV)
    ) dut4 (
        .clk(clk), .rst(rst), .addr(addr4), .we(we4), .wdata(wdata4), .rdata(rdata4),
        .irq(irq4)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] ra(input int ch, input int off);
        return BASE + 32'(16 * ch) + 32'(off);
    endfunction

    function automatic logic [31:0] st_addr();
        return BASE + 32'd32;
    endfunction

    // All tasks start and end at a falling edge; a write lands on the next rising edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1 d = rdata;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        for (int ch = 0; ch < 2; ch++) begin
            rd(ra(ch, 0), v); n_tests++;
            if (v !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl%0d: got %h want 0", ch, v); end
            rd(ra(ch, 4), v); n_tests++;
            if (v !== DEF_DIV) begin n_fail++; $display("FAIL reset_div%0d: got %h want %h", ch, v, DEF_DIV); end
            rd(ra(ch, 8), v); n_tests++;
            if (v !== 32'd0) begin n_fail++; $display("FAIL reset_count%0d: got %h want 0", ch, v); end
            rd(ra(ch, 12), v); n_tests++;
            if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp%0d: got %h want ffffffff", ch, v); end
        end
        rd(st_addr(), v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h want 0", v); end
    endtask

    // Model: after k cycles of running, ticks = k/div, COUNT = ticks mod (cmp+1)
    task automatic test_periodic(input int div, input int cmp);
        logic [31:0] c, s;
        int period, exp_c, exp_f;
        do_reset();
        period = (cmp + 1) * div;
        wr(ra(0, 4), 32'(div));
        wr(ra(0, 12), 32'(cmp));
        wr(ra(0, 0), 32'h3);
        for (int k = 0; k <= 2 * period + 2; k++) begin
            rd(ra(0, 8), c);
            rd(st_addr(), s);
            exp_c = (k / div) % (cmp + 1);
            exp_f = (k >= period) ? 1 : 0;
            n_tests++;
            if (c !== 32'(exp_c)) begin
                n_fail++;
                $display("FAIL periodic_count div=%0d cmp=%0d k=%0d: got %0d want %0d", div, cmp, k, c, exp_c);
            end
            n_tests++;
            if (s !== 32'(exp_f)) begin
                n_fail++;
                $display("FAIL periodic_flag div=%0d cmp=%0d k=%0d: got %h want %0d", div, cmp, k, s, exp_f);
            end
            n_tests++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL periodic_irq k=%0d: got %b want 0", k, irq); end
            step(1);
        end
    endtask

    task automatic test_oneshot_irq(input int div, input int cmp);
        logic [31:0] c, s, t;
        int m, exp_c;
        do_reset();
        m = (cmp + 1) * div;
        wr(ra(1, 4), 32'(div));
        wr(ra(1, 12), 32'(cmp));
        wr(ra(1, 0), 32'h5);
        for (int k = 0; k <= m + 3; k++) begin
            rd(st_addr(), s);
            rd(ra(1, 8), c);
            rd(ra(1, 0), t);
            exp_c = (k < m) ? (k / div) : cmp;
            n_tests++;
            if (s !== ((k >= m) ? 32'h2 : 32'h0)) begin
                n_fail++; $display("FAIL oneshot_flag div=%0d cmp=%0d k=%0d: got %h", div, cmp, k, s);
            end
            n_tests++;
            if (c !== 32'(exp_c)) begin
                n_fail++; $display("FAIL oneshot_count k=%0d: got %0d want %0d", k, c, exp_c);
            end
            n_tests++;
            if (t !== ((k >= m) ? 32'h4 : 32'h5)) begin
                n_fail++; $display("FAIL oneshot_ctrl k=%0d: got %h", k, t);
            end
            n_tests++;
            if (irq !== ((k >= m + 1) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL oneshot_irq k=%0d: got %b want %b", k, irq, k >= m + 1);
            end
            step(1);
        end
        wr(st_addr(), 32'h2);
        step(1);
        rd(st_addr(), s); n_tests++;
        if (s !== 32'd0) begin n_fail++; $display("FAIL oneshot_w1c_status: got %h want 0", s); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_w1c_irq: got %b want 0", irq); end
    endtask

    task automatic test_count_collision();
        logic [31:0] v;
        do_reset();
        wr(ra(0, 4), 32'd4);
        wr(ra(0, 12), 32'd0);
        wr(ra(0, 0), 32'h1);
        step(3);
        wr(ra(0, 8), 32'd0);  // lands on the first tick, which would have matched
        rd(ra(0, 8), v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL coll_count: got %h want 0", v); end
        rd(st_addr(), v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL coll_noflag: got %h want 0", v); end
        rd(ra(0, 0), v); n_tests++;
        if (v !== 32'h1) begin n_fail++; $display("FAIL coll_en_kept: got %h want 1", v); end
        step(3);
        rd(st_addr(), v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL coll_early: got %h want 0", v); end
        step(1);
        rd(st_addr(), v); n_tests++;
        if (v !== 32'h1) begin n_fail++; $display("FAIL coll_next_tick: got %h want 1", v); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] v;
        do_reset();
        wr(ra(0, 4), 32'd1);
        wr(ra(0, 12), 32'd3);
        wr(ra(0, 0), 32'h1);
        step(3);
        wr(st_addr(), 32'h1);  // same edge as the match
        rd(st_addr(), v); n_tests++;
        if (v !== 32'h1) begin n_fail++; $display("FAIL w1c_coll: got %h want 1", v); end
        wr(st_addr(), 32'h1);
        rd(st_addr(), v); n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h want 0", v); end
    endtask

    task automatic test_boundaries();
        logic [31:0] v;
        do_reset();
        wr(ra(0, 4), 32'd0);
        wr(ra(0, 12), 32'd0);
        wr(ra(0, 8), 32'd3);
        wr(ra(0, 0), 32'h3);
        step(20);
        rd(ra(0, 8), v); n_tests++;
        if (v !== 32'd3) begin n_fail++; $display("FAIL div0_count: got %h want 3", v); end
        rd(st_addr(), v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL div0_flag: got %h want 0", v); end
        do_reset();
        wr(ra(0, 4), 32'd1);
        wr(ra(0, 12), 32'd0);
        wr(ra(0, 8), 32'hFFFF_FFFF);
        wr(ra(0, 0), 32'h1);
        step(1);
        rd(ra(0, 8), v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL wrap_count: got %h want 0", v); end
        rd(st_addr(), v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL wrap_noflag: got %h want 0", v); end
        step(1);
        rd(st_addr(), v); n_tests++;
        if (v !== 32'h1) begin n_fail++; $display("FAIL wrap_flag: got %h want 1", v); end
        rd(ra(0, 0), v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL wrap_en: got %h want 0", v); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] v;
        do_reset();
        wr(ra(0, 4), 32'd1);
        wr(ra(0, 12), 32'd0);
        wr(ra(0, 0), 32'h7);
        wr(ra(1, 4), 32'd2);
        wr(ra(1, 12), 32'd9);
        wr(ra(1, 0), 32'h1);
        step(5);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL midrun_pre_irq: got %b want 1", irq); end
        rst = 1'b1;
        #1; n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL midrun_async_irq: got %b want 0", irq); end
        step(2);
        rst = 1'b0;
        step(10);
        for (int ch = 0; ch < 2; ch++) begin
            rd(ra(ch, 0), v); n_tests++;
            if (v !== 32'd0) begin n_fail++; $display("FAIL midrun_ctrl%0d: got %h want 0", ch, v); end
            rd(ra(ch, 4), v); n_tests++;
            if (v !== DEF_DIV) begin n_fail++; $display("FAIL midrun_div%0d: got %h", ch, v); end
            rd(ra(ch, 8), v); n_tests++;
            if (v !== 32'd0) begin n_fail++; $display("FAIL midrun_count%0d: got %h want 0", ch, v); end
            rd(ra(ch, 12), v); n_tests++;
            if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL midrun_cmp%0d: got %h", ch, v); end
        end
        rd(st_addr(), v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL midrun_status: got %h want 0", v); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL midrun_irq: got %b want 0", irq); end
    endtask

    task automatic test_div_rewrite();
        logic [31:0] v;
        int dn;
        do_reset();
        dn = int'($urandom_range(1, 6));
        wr(ra(0, 4), 32'd10);
        wr(ra(0, 12), 32'd1000);
        wr(ra(0, 0), 32'h1);
        step(3);
        wr(ra(0, 4), 32'(dn));
        step(dn - 1);
        rd(ra(0, 8), v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL divrw_early dn=%0d: got %h want 0", dn, v); end
        step(1);
        rd(ra(0, 8), v); n_tests++;
        if (v !== 32'd1) begin n_fail++; $display("FAIL divrw_tick dn=%0d: got %h want 1", dn, v); end
    endtask

    task automatic test_decode();
        logic [31:0] v;
        do_reset();
        rd(BASE + 32'h24, v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL dec_status_plus4: got %h want 0", v); end
        rd(BASE - 32'd4, v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL dec_below_base: got %h want 0", v); end
        rd(BASE + 32'h3C, v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL dec_ch3_on_2ch: got %h want 0", v); end
        wr(BASE + 32'h28, 32'hFFFF_FFFF);
        rd(ra(0, 8), v); n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL dec_unmapped_wr: got %h want 0", v); end
        addr4 = BASE + 32'h3C; wdata4 = 32'h0000_1234; we4 = 1'b1;
        step(1);
        we4 = 1'b0;
        #1; n_tests++;
        if (rdata4 !== 32'h0000_1234) begin n_fail++; $display("FAIL dec_ch3_cmp: got %h want 1234", rdata4); end
        addr4 = BASE + 32'h34;
        #1; n_tests++;
        if (rdata4 !== DEF_DIV) begin n_fail++; $display("FAIL dec_ch3_div: got %h", rdata4); end
        addr4 = BASE + 32'h40;
        #1; n_tests++;
        if (rdata4 !== 32'd0) begin n_fail++; $display("FAIL dec_status4: got %h want 0", rdata4); end
    endtask

    task automatic test_readback_random();
        logic [31:0] v, d_div, d_cmp, d_cnt, d_ctl;
        do_reset();
        for (int ch = 0; ch < 2; ch++) begin
            d_div = $urandom; d_cmp = $urandom; d_cnt = $urandom;
            d_ctl = $urandom & 32'hFFFF_FFFE;  // EN kept low so COUNT stays still
            wr(ra(ch, 4), d_div);
            wr(ra(ch, 12), d_cmp);
            wr(ra(ch, 8), d_cnt);
            wr(ra(ch, 0), d_ctl);
            rd(ra(ch, 4), v); n_tests++;
            if (v !== d_div) begin n_fail++; $display("FAIL rb_div%0d: got %h want %h", ch, v, d_div); end
            rd(ra(ch, 12), v); n_tests++;
            if (v !== d_cmp) begin n_fail++; $display("FAIL rb_cmp%0d: got %h want %h", ch, v, d_cmp); end
            rd(ra(ch, 8), v); n_tests++;
            if (v !== d_cnt) begin n_fail++; $display("FAIL rb_count%0d: got %h want %h", ch, v, d_cnt); end
            rd(ra(ch, 0), v); n_tests++;
            if (v !== (d_ctl & 32'h7)) begin
                n_fail++; $display("FAIL rb_ctrl%0d: got %h want %h", ch, v, d_ctl & 32'h7);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_periodic(4, 2);
        for (int i = 0; i < 3; i++) begin
            test_periodic(int'($urandom_range(1, 5)), int'($urandom_range(0, 4)));
        end
        test_oneshot_irq(1, 5);
        test_oneshot_irq(int'($urandom_range(1, 4)), int'($urandom_range(0, 6)));
        test_count_collision();
        test_w1c_collision();
        test_boundaries();
        test_reset_midrun();
        test_div_rewrite();
        test_decode();
        test_readback_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_timer_peripheral.md
MULTI_TIMER_PERIPHERAL -- requirements
Module: multi_timer_peripheral

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent timer channels (1..8).
REQ-002 SHALL have parameter BASE_ADDR, default 32'hFFFF_F040, first byte address of the register window.
REQ-003 SHALL have parameter DEFAULT_DIV, default 50000000, reset value of every DIV register (1 tick per second at 50 MHz).
REQ-004 SHALL have port clk, input, 1, the system clock.
REQ-005 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-006 SHALL have port addr, input, 32, the byte address of the bus access.
REQ-007 SHALL have port we, input, 1, the write strobe, sampled on the clk rising edge.
REQ-008 SHALL have port wdata, input, 32, the write data.
REQ-009 SHALL have port rdata, output, 32, the read data, combinational from addr.
REQ-010 SHALL have port irq, output, 1, the interrupt request, level, registered.

Function
REQ-011 SHALL give channel n (n = 0..NUM_CH-1) this register map at BASE_ADDR+16n:
- +0x0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN; other bits read 0.
- +0x4 DIV: prescale factor.
- +0x8 COUNT: read/write.
- +0xC CMP: compare value.
REQ-012 SHALL place STATUS at BASE_ADDR+16*NUM_CH: bit n is the match flag of channel n, write-1-to-clear; upper bits read 0.
REQ-013 SHALL return 0 on rdata for any unmapped address and SHALL ignore writes to unmapped addresses.
REQ-014 SHALL advance each channel's prescaler counter by 1 per clk while EN=1 and DIV!=0, and SHALL hold it at 0 otherwise.
REQ-015 SHALL assert that channel's tick for one cycle when its prescaler counter >= DIV-1, and SHALL reset the prescaler counter to 0 in that cycle.
REQ-016 SHALL, on a tick with COUNT != CMP, set COUNT to COUNT+1 (32-bit, wraps 0xFFFFFFFF->0).
REQ-017 SHALL, on a tick with COUNT == CMP, set the channel's STATUS flag and then:
- PERIODIC=1: set COUNT to 0.
- PERIODIC=0: hold COUNT and clear EN (one-shot).
REQ-018 SHALL therefore give a periodic match interval of exactly (CMP+1)*DIV clk cycles.
REQ-019 SHALL, on any write to DIV, reset that channel's prescaler counter to 0 in the same edge.
REQ-020 SHALL let a software write to COUNT take priority over a same-cycle tick; the tick is lost and the flag is not set.
REQ-021 SHALL let a flag set take priority over a same-cycle W1C clear of the same bit.
REQ-022 SHALL register irq = OR over n of (STATUS[n] & IRQ_EN[n]), giving 1 cycle of latency after the flag update.
REQ-023 SHALL take effect on register writes at the clk edge where we=1; rdata reflects the new value from the next cycle.

Reset
REQ-024 SHALL on rst force the following, with rdata following the combinational decode of those values:
- CTRL=0, COUNT=0, CMP=0xFFFFFFFF, DIV=DEFAULT_DIV.
- Prescaler counters=0, STATUS=0, irq=0.
REQ-025 SHALL abandon any in-progress count or one-shot on reset assertion, with no pending flag surviving.

Structure
REQ-026 SHALL put register offsets (CTRL/DIV/COUNT/CMP), CTRL bit positions and the channel stride (16) in a shared package timer_pkg.
REQ-027 SHALL implement one sub-module timer_channel holding CTRL/DIV/COUNT/CMP, the prescaler and match logic, instantiated NUM_CH times by generate.
REQ-028 SHALL keep the address decode, STATUS register, rdata mux and irq register in the top module.

Verification
REQ-029 Periodic mode: ch0 DIV=4, CMP=2, CTRL=0b011 -> flag0 sets every 12 cycles, COUNT sequence 0,1,2,0.
REQ-030 One-shot with interrupt: ch1 DIV=1, CMP=5, CTRL=0b101 -> flag1 sets after 6 cycles, EN reads 0, COUNT holds 5, irq=1 one cycle later; W1C 0x2 to STATUS -> irq=0.
REQ-031 Collisions:
- COUNT write 0 on the tick cycle -> COUNT=0, no flag.
- W1C on the match cycle -> flag stays 1.
REQ-032 Boundaries: DIV=0 with EN=1 -> COUNT frozen; COUNT=0xFFFFFFFF, CMP=0 -> tick wraps COUNT to 0, the next tick sets the flag.
REQ-033 Mid-run: rst mid-run -> all registers at reset values, irq=0; DIV rewrite mid-period -> next tick exactly DIV_new cycles later.
REQ-034 Decode: read of STATUS+4 and of unmapped addresses -> 0; NUM_CH=4 instance -> channel 3 registers at BASE_ADDR+0x30.
